// File: rtl/servo_slew_ctrl.sv
// Multi-channel servo position slew limiter: once per frame, each channel's
// position moves toward its commanded target by at most its rate.
`timescale 1ns/1ps
module servo_slew_ctrl #(
  parameter int CLK_FREQUENCY = 12000000,
  parameter int FRAME_HZ      = 50,
  parameter int NUM_CH        = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_ch,
  input  logic [7:0]          cmd_target,
  input  logic [7:0]          cmd_rate,
  output logic [NUM_CH*8-1:0] pos,
  output logic [NUM_CH-1:0]   busy,
  output logic                frame_tick
);
  localparam int FRAME_COUNT = CLK_FREQUENCY / FRAME_HZ;
  localparam int CW          = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1;

  generate
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("servo_slew_ctrl: NUM_CH must be 1..8");
    end
    if (NUM_CH + 1 >= FRAME_COUNT) begin : g_bad_frame
      $error("servo_slew_ctrl: update pass does not fit in a frame");
    end
  endgenerate

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_tick;
  logic          w_accept;

  // Frame timebase free-runs regardless of the update FSM.
  assign w_tick     = (r_cnt == CW'(FRAME_COUNT - 1));
  assign frame_tick = w_tick & ~rst;

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    cmd_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = ~rst;
        if (w_tick) begin
          w_state_nxt = UPDATE;
          w_idx_nxt   = '0;
        end
      end
      UPDATE: begin
        if (r_idx == 3'(NUM_CH - 1)) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = cmd_valid & cmd_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] r_tgt, r_rate, r_pos;
      logic [8:0] w_t9, w_p9, w_r9, w_d9, w_nx9;

      // 9-bit step math keeps pos +/- rate from wrapping before the clamp.
      always_comb begin
        w_t9 = {1'b0, r_tgt};
        w_p9 = {1'b0, r_pos};
        w_r9 = {1'b0, r_rate};
        w_d9 = (w_t9 > w_p9) ? (w_t9 - w_p9) : (w_p9 - w_t9);
        if (w_r9 == 9'd0 || w_d9 <= w_r9) w_nx9 = w_t9;
        else if (w_t9 > w_p9)             w_nx9 = w_p9 + w_r9;
        else                              w_nx9 = w_p9 - w_r9;
      end

      // Out-of-range channel numbers never match a lane, so they are dropped.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tgt  <= 8'd128;
          r_rate <= 8'd0;
          r_pos  <= 8'd128;
        end else begin
          if (w_accept && cmd_ch == 3'(gi)) begin
            r_tgt  <= cmd_target;
            r_rate <= cmd_rate;
          end
          if (r_state == UPDATE && r_idx == 3'(gi)) r_pos <= w_nx9[7:0];
        end
      end

      assign pos[gi*8 +: 8] = r_pos;
      assign busy[gi]       = (r_tgt != r_pos);
    end
  endgenerate
endmodule
